// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Serial Mealy detector for a loadable PAT_LEN-bit pattern with
//            overlap control and a saturating, sticky-flagged match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int                 PAT_LEN   = 3,
    parameter logic [PAT_LEN-1:0] PAT_RESET = 3'b101,
    parameter int                 CNT_W     = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Din_valid,
    input  logic               Din,
    input  logic               Load,
    input  logic [PAT_LEN-1:0] Pattern,
    input  logic               Overlap,
    input  logic               Clear,
    output logic               Y,
    output logic               Y_q,
    output logic [CNT_W-1:0]   Match_count,
    output logic               Count_sat
);

    localparam int                FILL_W    = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic               r_y_q;

    logic               w_accept;
    logic               w_match;
    logic [PAT_LEN-2:0] w_hist_next;
    logic [CNT_W-1:0]   w_cnt_inc;

    // A two-bit pattern keeps a single history bit, so there is nothing to shift.
    generate
        if (PAT_LEN > 2) begin : g_hist_wide
            assign w_hist_next = {r_hist[PAT_LEN-3:0], Din};
        end else begin : g_hist_narrow
            assign w_hist_next = Din;
        end
    endgenerate

    assign w_accept  = Din_valid & ~Load;
    assign w_match   = w_accept && (r_fill == FILL_FULL) && ({r_hist, Din} == r_pat);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pat  <= PAT_RESET;
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
            r_y_q  <= 1'b0;
        end else begin
            r_y_q <= w_match;

            if (Load) begin
                r_pat  <= Pattern;
                r_fill <= '0;
            end else if (Din_valid) begin
                r_hist <= w_hist_next;
                // Non-overlapping mode discards the whole window after a hit.
                if (w_match && !Overlap) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end

            if (Clear) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_match && (r_cnt != CNT_MAX)) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign Y           = w_match;
    assign Y_q         = r_y_q;
    assign Match_count = r_cnt;
    assign Count_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Brief    : Directed self-checking bench for seq_detector_param (default
//            3-bit instance plus a 2-bit pattern / 2-bit counter instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic       Clk = 1'b0;
    logic       Rst_n;

    logic       a_valid, a_din, a_load, a_overlap, a_clear;
    logic [2:0] a_pattern;
    logic       a_y, a_y_q, a_sat;
    logic [7:0] a_count;

    logic       b_valid, b_din, b_load, b_overlap, b_clear;
    logic [1:0] b_pattern;
    logic       b_y, b_y_q, b_sat;
    logic [1:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    seq_detector_param u_dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .Din_valid(a_valid), .Din(a_din), .Load(a_load),
        .Pattern(a_pattern), .Overlap(a_overlap), .Clear(a_clear),
        .Y(a_y), .Y_q(a_y_q), .Match_count(a_count), .Count_sat(a_sat)
    );

    seq_detector_param #(.PAT_LEN(2), .PAT_RESET(2'b11), .CNT_W(2)) u_dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .Din_valid(b_valid), .Din(b_din), .Load(b_load),
        .Pattern(b_pattern), .Overlap(b_overlap), .Clear(b_clear),
        .Y(b_y), .Y_q(b_y_q), .Match_count(b_count), .Count_sat(b_sat)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic beat_a(input logic v, input logic d, input logic exp_y, input string tag);
        a_valid = v;
        a_din   = d;
        #1;
        check_value({tag, " Y"}, a_y, exp_y);
        @(posedge Clk);
        #1;
        check_value({tag, " Y_q"}, a_y_q, exp_y);
        a_load  = 1'b0;
        a_clear = 1'b0;
    endtask

    task automatic beat_b(input logic v, input logic d, input logic exp_y, input string tag);
        b_valid = v;
        b_din   = d;
        #1;
        check_value({tag, " Y"}, b_y, exp_y);
        @(posedge Clk);
        #1;
        check_value({tag, " Y_q"}, b_y_q, exp_y);
        b_load  = 1'b0;
        b_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0;
        a_valid = 1'b1; a_din = 1'b1; a_load = 1'b0; a_overlap = 1'b1; a_clear = 1'b0;
        a_pattern = 3'b000;
        b_valid = 1'b0; b_din = 1'b0; b_load = 1'b0; b_overlap = 1'b1; b_clear = 1'b0;
        b_pattern = 2'b00;
        #1;
        check_value("reset Y", a_y, 1'b0);
        check_value("reset Y_q", a_y_q, 1'b0);
        check_value("reset count", a_count, 8'd0);
        check_value("reset sat", a_sat, 1'b0);
        check_value("reset b count", b_count, 2'd0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Overlapping: 1,0,1,0,1 -> hits on beats 3 and 5
        beat_a(1, 1, 0, "ov b1");
        beat_a(1, 0, 0, "ov b2");
        beat_a(1, 1, 1, "ov b3");
        check_value("ov count after b3", a_count, 8'd1);
        beat_a(1, 0, 0, "ov b4");
        beat_a(1, 1, 1, "ov b5");
        check_value("ov count", a_count, 8'd2);

        // Flush via Load (same pattern), clear counter, then non-overlapping run
        a_load = 1'b1; a_pattern = 3'b101; a_clear = 1'b1;
        beat_a(1, 0, 0, "load1");
        check_value("clear count", a_count, 8'd0);
        a_overlap = 1'b0;
        beat_a(1, 1, 0, "nov b1");
        beat_a(1, 0, 0, "nov b2");
        beat_a(1, 1, 1, "nov b3");
        beat_a(1, 0, 0, "nov b4");
        beat_a(1, 1, 0, "nov b5");
        check_value("nov count", a_count, 8'd1);

        // Gaps in Din_valid must not disturb the history
        a_load = 1'b1; a_overlap = 1'b1;
        beat_a(1, 1, 0, "load2");
        beat_a(1, 1, 0, "gap c1");
        beat_a(0, 0, 0, "gap c2");
        beat_a(1, 0, 0, "gap c3");
        beat_a(0, 1, 0, "gap c4");
        beat_a(1, 1, 1, "gap c5");
        check_value("gap count", a_count, 8'd2);

        // Load 110 after 1,1: Load cycle and next two beats silent
        beat_a(1, 1, 0, "pre b1");
        beat_a(1, 1, 0, "pre b2");
        a_load = 1'b1; a_pattern = 3'b110;
        beat_a(1, 0, 0, "load3");
        beat_a(1, 1, 0, "new b1");
        beat_a(1, 1, 0, "new b2");
        beat_a(1, 0, 1, "new b3");
        check_value("new count", a_count, 8'd3);
        a_valid = 1'b0;

        // 2-bit counter saturation with pattern 11 on all-ones stream
        beat_b(1, 1, 0, "sat b1");
        beat_b(1, 1, 1, "sat b2");
        beat_b(1, 1, 1, "sat b3");
        check_value("sat count 2", b_count, 2'd2);
        check_value("sat flag early", b_sat, 1'b0);
        beat_b(1, 1, 1, "sat b4");
        check_value("sat count 3", b_count, 2'd3);
        check_value("sat flag set", b_sat, 1'b1);
        beat_b(1, 1, 1, "sat b5");
        check_value("sat count held", b_count, 2'd3);
        check_value("sat flag sticky", b_sat, 1'b1);
        b_clear = 1'b1;
        beat_b(1, 1, 1, "clr hit");
        check_value("clr count", b_count, 2'd0);
        check_value("clr sat", b_sat, 1'b0);
        b_valid = 1'b0;

        // Mid-stream reset restores pattern 101 and drops history
        beat_a(1, 1, 0, "mid b1");
        beat_a(1, 0, 0, "mid b2");
        Rst_n = 1'b0;
        a_din = 1'b1;
        #1;
        check_value("rst Y", a_y, 1'b0);
        check_value("rst Y_q", a_y_q, 1'b0);
        check_value("rst count", a_count, 8'd0);
        check_value("rst sat", a_sat, 1'b0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        beat_a(1, 1, 0, "post b1");
        beat_a(1, 0, 0, "post b2");
        beat_a(1, 1, 1, "post b3");
        check_value("post count", a_count, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
